// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one word fetch at a time, feeds the fetch/decode register.
// Latency: output register loads the cycle after the response; zero-wait memory gives 1 instr / 2 cycles.
// Backpressure: decode stall parks a late response in a one-entry hold buffer; no new request until it drains.

package fetch_stage_pkg;

  typedef struct packed {
    logic stall;
    logic flush;
  } fetchDecodeControl_;

  typedef struct packed {
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
  } fetchDecodePayload_;

endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  fetchDecodeControl_ fetchDecodeControl,
  input  logic               redirectValid,
  input  logic [31:0]        redirectTarget,
  output logic               instructionRequestValid,
  input  logic               instructionRequestReady,
  output logic [31:0]        instructionRequestAddress,
  input  logic               instructionResponseValid,
  input  logic [31:0]        instructionResponseData,
  output fetchDecodePayload_ fetchDecodePayload
);

  typedef enum logic [1:0] {
    ST_REQUEST = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  // Set when the outstanding response belongs to a fetch made before a redirect.
  logic               discard_q, discard_d;
  // Hold buffer: occupied exactly while in ST_HOLD, so no separate valid bit.
  logic [31:0]        hold_instr_q, hold_instr_d;
  logic [31:0]        hold_pc_q, hold_pc_d;
  fetchDecodePayload_ payload_q, payload_d;

  logic               req_fire;
  logic               deliver;
  logic [31:0]        deliver_instr;
  logic [31:0]        deliver_pc;

  // Request outputs: only ST_REQUEST asks memory, and never while reset is held.
  always_comb begin
    instructionRequestValid   = (state_q == ST_REQUEST) && !reset;
    instructionRequestAddress = pc_q;
    fetchDecodePayload        = payload_q;
  end

  assign req_fire = instructionRequestValid && instructionRequestReady;

  // Next state, PC, discard flag and hold buffer; redirect overrides everything at the end.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = instructionResponseData;
    deliver_pc    = pc_q;

    case (state_q)
      ST_REQUEST: begin
        if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (instructionResponseValid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQUEST;
          end else if (!fetchDecodeControl.stall) begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQUEST;
          end else begin
            hold_instr_d = instructionResponseData;
            hold_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!fetchDecodeControl.stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          state_d       = ST_REQUEST;
        end
      end
      default: begin
        state_d = ST_REQUEST;
      end
    endcase

    if (redirectValid) begin
      pc_d    = redirectTarget & 32'hFFFF_FFFC;
      deliver = 1'b0;
      // A fetch is (or is about to be) in flight to the old PC: wait it out and drop it.
      if (((state_q == ST_WAIT) && !instructionResponseValid) ||
          ((state_q == ST_REQUEST) && req_fire)) begin
        state_d   = ST_WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = ST_REQUEST;
        discard_d = 1'b0;
      end
    end
  end

  // Fetch/decode register: flush clears valid only, stall freezes, otherwise load or bubble.
  always_comb begin
    payload_d = payload_q;
    if (fetchDecodeControl.flush) begin
      payload_d.valid = 1'b0;
    end else if (!fetchDecodeControl.stall) begin
      if (deliver) begin
        payload_d.valid               = 1'b1;
        payload_d.instruction         = deliver_instr;
        payload_d.programCounter      = deliver_pc;
        payload_d.programCounterPlus4 = deliver_pc + 32'd4;
      end else begin
        payload_d.valid = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_REQUEST;
      pc_q         <= RESET_VECTOR;
      discard_q    <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      payload_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      payload_q    <= payload_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with configurable ready/latency plus directed and random scenarios.
// Latency of the bench clock step is one cycle per tick(); outputs sampled 1 time unit after the edge.
// Random scenario is scored against a stream model: deliveries and requests are consecutive words from the last redirect.

module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  fetchDecodeControl_ ctrl;
  logic               redirect_v;
  logic [31:0]        redirect_t;
  logic               req_v;
  logic               req_r;
  logic [31:0]        req_a;
  logic               resp_v;
  logic [31:0]        resp_d;
  fetchDecodePayload_ payload;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clock                     (clock),
    .reset                     (reset),
    .fetchDecodeControl        (ctrl),
    .redirectValid             (redirect_v),
    .redirectTarget            (redirect_t),
    .instructionRequestValid   (req_v),
    .instructionRequestReady   (req_r),
    .instructionRequestAddress (req_a),
    .instructionResponseValid  (resp_v),
    .instructionResponseData   (resp_d),
    .fetchDecodePayload        (payload)
  );

  always #5 clock = ~clock;

  // Memory model knobs and state
  int          rdy_mode;   // 0 never ready, 1 always ready, 2 random
  int          lat_lo, lat_hi;
  bit          data_const;
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay;

  // What happened at the last clock edge
  bit                 acc;
  logic [31:0]        acc_addr;
  bit                 pre_reset, pre_stall, pre_flush, pre_redir;
  logic [31:0]        pre_target;
  fetchDecodePayload_ prev_payload;
  bit                 loaded, got;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (data_const) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    resp_v = mem_pending && (mem_delay == 0);
    resp_d = resp_v ? mem_word(mem_addr) : $urandom;
    case (rdy_mode)
      0:       req_r = 1'b0;
      1:       req_r = 1'b1;
      default: req_r = 1'($urandom_range(0, 1));
    endcase
    acc          = req_v && req_r;
    acc_addr     = req_a;
    pre_reset    = reset;
    pre_stall    = ctrl.stall;
    pre_flush    = ctrl.flush;
    pre_redir    = redirect_v;
    pre_target   = redirect_t;
    prev_payload = payload;
    @(posedge clock);
    #1;
    loaded = !pre_reset && !pre_flush && !pre_stall;
    got    = loaded && payload.valid;
    if (pre_reset) begin
      mem_pending = 1'b0;
    end else begin
      if (resp_v) mem_pending = 1'b0;
      else if (mem_pending && mem_delay > 0) mem_delay = mem_delay - 1;
      if (acc) begin
        mem_pending = 1'b1;
        mem_addr    = acc_addr;
        mem_delay   = int'($urandom_range(lat_hi, lat_lo));
      end
    end
  endtask

  task automatic test_reset();
    fetchDecodePayload_ zero_p;
    zero_p     = '0;
    reset      = 1'b1;
    ctrl       = '0;
    redirect_v = 1'b0;
    redirect_t = 32'h0;
    rdy_mode   = 1;
    lat_lo     = 0;
    lat_hi     = 0;
    data_const = 1'b0;
    tick();
    checks++;
    if (req_v !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_v); end
    checks++;
    if (payload !== zero_p) begin errors++; $display("FAIL reset_payload: got %h expected 0", payload); end
    tick();
    checks++;
    if (req_v !== 1'b0) begin errors++; $display("FAIL reset_req_valid2: got %b expected 0", req_v); end
    reset = 1'b0;
    #1;
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h0) begin
      errors++; $display("FAIL reset_first_req: got vld=%b addr=%h expected vld=1 addr=00000000", req_v, req_a);
    end
  endtask

  task automatic test_basic();
    fetchDecodePayload_ exp_p;
    logic [31:0] pc;
    data_const = 1'b1;
    rdy_mode   = 1;
    lat_lo     = 0;
    lat_hi     = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pc = 32'(4 * (i / 2));
      if (i % 2 == 0) begin
        checks++;
        if (acc !== 1'b1 || acc_addr !== pc) begin
          errors++; $display("FAIL basic_req%0d: got acc=%b addr=%h expected acc=1 addr=%h", i, acc, acc_addr, pc);
        end
        checks++;
        if (payload.valid !== 1'b0) begin
          errors++; $display("FAIL basic_bubble%0d: got valid=%b expected 0", i, payload.valid);
        end
      end else begin
        exp_p = '{valid: 1'b1, instruction: 32'h13, programCounter: pc, programCounterPlus4: pc + 32'd4};
        checks++;
        if (payload !== exp_p) begin
          errors++; $display("FAIL basic_payload%0d: got %h expected %h", i, payload, exp_p);
        end
      end
    end
  endtask

  task automatic test_ready_stall();
    int n_acc;
    tick();                         // accept 0xC
    tick();                         // deliver 0xC
    checks++;
    if (!got || payload.programCounter !== 32'hC) begin
      errors++; $display("FAIL rdy_prefetch: got got=%b pc=%h expected got=1 pc=0000000c", got, payload.programCounter);
    end
    rdy_mode = 0;
    n_acc    = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_v !== 1'b1 || req_a !== 32'h10) begin
        errors++; $display("FAIL rdy_hold%0d: got vld=%b addr=%h expected vld=1 addr=00000010", i, req_v, req_a);
      end
      tick();
      n_acc += int'(acc);
    end
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h10) begin
      errors++; $display("FAIL rdy_hold_end: got vld=%b addr=%h expected vld=1 addr=00000010", req_v, req_a);
    end
    rdy_mode = 1;
    tick();
    n_acc += int'(acc);
    tick();
    n_acc += int'(acc);
    checks++;
    if (n_acc != 1) begin errors++; $display("FAIL rdy_accept_count: got %0d expected 1", n_acc); end
    checks++;
    if (!got || payload.programCounter !== 32'h10) begin
      errors++; $display("FAIL rdy_deliver: got got=%b pc=%h expected got=1 pc=00000010", got, payload.programCounter);
    end
  endtask

  task automatic test_stall_hold();
    fetchDecodePayload_ p0, exp_p;
    data_const = 1'b0;
    tick();                         // accept 0x14
    ctrl.stall = 1'b1;
    p0 = payload;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (payload !== p0 || req_v !== 1'b0) begin
        errors++; $display("FAIL hold_frozen%0d: got payload=%h vld=%b expected payload=%h vld=0", i, payload, req_v, p0);
      end
    end
    ctrl.stall = 1'b0;
    tick();
    exp_p = '{valid: 1'b1, instruction: mem_word(32'h14), programCounter: 32'h14, programCounterPlus4: 32'h18};
    checks++;
    if (payload !== exp_p) begin errors++; $display("FAIL hold_release: got %h expected %h", payload, exp_p); end
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h18) begin
      errors++; $display("FAIL hold_next_req: got vld=%b addr=%h expected vld=1 addr=00000018", req_v, req_a);
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    lat_lo = 1;
    lat_hi = 1;
    tick();                         // accept 0x18, response two edges later
    redirect_v = 1'b1;
    redirect_t = 32'h103;
    ctrl.flush = 1'b1;
    tick();
    redirect_v = 1'b0;
    ctrl.flush = 1'b0;
    lat_lo     = 0;
    lat_hi     = 0;
    checks++;
    if (req_v !== 1'b0 || payload.valid !== 1'b0) begin
      errors++; $display("FAIL redir_wait: got vld=%b pvalid=%b expected 0 0", req_v, payload.valid);
    end
    tick();                         // stale response arrives and is dropped
    checks++;
    if (payload.valid !== 1'b0) begin errors++; $display("FAIL redir_drop: got valid=%b expected 0", payload.valid); end
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h100) begin
      errors++; $display("FAIL redir_req: got vld=%b addr=%h expected vld=1 addr=00000100", req_v, req_a);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = got;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL redir_timeout: got no delivery expected one within 10 cycles");
    end else if (payload.programCounter !== 32'h100 || payload.instruction !== mem_word(32'h100)) begin
      errors++; $display("FAIL redir_first: got pc=%h instr=%h expected pc=00000100 instr=%h",
                         payload.programCounter, payload.instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_flush_redirect();
    fetchDecodePayload_ p, exp_p;
    bit found;
    ctrl.stall = 1'b1;
    ctrl.flush = 1'b1;
    p = payload;
    tick();                         // request 0x104 accepted meanwhile
    exp_p = p;
    exp_p.valid = 1'b0;
    checks++;
    if (payload !== exp_p) begin errors++; $display("FAIL flush_stall: got %h expected %h", payload, exp_p); end
    ctrl.stall = 1'b0;
    redirect_v = 1'b1;
    redirect_t = 32'h200;
    tick();                         // response for 0x104 arrives with the redirect
    redirect_v = 1'b0;
    ctrl.flush = 1'b0;
    checks++;
    if (payload.valid !== 1'b0) begin errors++; $display("FAIL flush_redir_valid: got %b expected 0", payload.valid); end
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h200) begin
      errors++; $display("FAIL flush_redir_req: got vld=%b addr=%h expected vld=1 addr=00000200", req_v, req_a);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = got;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL flush_redir_timeout: got no delivery expected one within 10 cycles");
    end else if (payload.programCounter !== 32'h200) begin
      errors++; $display("FAIL flush_redir_first: got pc=%h expected 00000200", payload.programCounter);
    end
  endtask

  task automatic test_wrap();
    rdy_mode   = 0;
    redirect_v = 1'b1;
    ctrl.flush = 1'b1;
    redirect_t = 32'hFFFF_FFFC;
    tick();
    redirect_v = 1'b0;
    ctrl.flush = 1'b0;
    rdy_mode   = 1;
    tick();
    checks++;
    if (acc !== 1'b1 || acc_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: got acc=%b addr=%h expected acc=1 addr=fffffffc", acc, acc_addr);
    end
    tick();
    checks++;
    if (!got || payload.programCounter !== 32'hFFFF_FFFC || payload.programCounterPlus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_payload: got got=%b pc=%h pc4=%h expected got=1 pc=fffffffc pc4=00000000",
                         got, payload.programCounter, payload.programCounterPlus4);
    end
    checks++;
    if (req_v !== 1'b1 || req_a !== 32'h0) begin
      errors++; $display("FAIL wrap_next_req: got vld=%b addr=%h expected vld=1 addr=00000000", req_v, req_a);
    end
  endtask

  task automatic test_random();
    logic [31:0]        exp_req, exp_del, t;
    fetchDecodePayload_ exp_hold;
    int                 n_del;
    rdy_mode   = 2;
    lat_lo     = 0;
    lat_hi     = 3;
    data_const = 1'b0;
    exp_req    = 32'h0;
    exp_del    = 32'h0;
    n_del      = 0;
    for (int i = 0; i < 3000; i++) begin
      ctrl.stall = ($urandom_range(0, 3) == 0);
      redirect_v = ($urandom_range(0, 24) == 0);
      ctrl.flush = redirect_v;
      t = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      redirect_t = t;
      tick();
      if (acc) begin
        checks++;
        if (acc_addr !== exp_req) begin
          errors++; $display("FAIL rnd_req c%0d: got addr=%h expected %h", i, acc_addr, exp_req);
        end
        exp_req = acc_addr + 32'd4;
      end
      if (got) begin
        checks++;
        if (payload.programCounter !== exp_del || payload.instruction !== mem_word(exp_del) ||
            payload.programCounterPlus4 !== exp_del + 32'd4) begin
          errors++; $display("FAIL rnd_deliver c%0d: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h", i,
                             payload.programCounter, payload.instruction, payload.programCounterPlus4,
                             exp_del, mem_word(exp_del), exp_del + 32'd4);
        end
        exp_del = payload.programCounter + 32'd4;
        n_del++;
      end else if (!loaded) begin
        exp_hold = prev_payload;
        if (pre_flush) exp_hold.valid = 1'b0;
        checks++;
        if (payload !== exp_hold) begin
          errors++; $display("FAIL rnd_hold c%0d: got %h expected %h", i, payload, exp_hold);
        end
      end
      if (pre_redir) begin
        exp_req = pre_target & 32'hFFFF_FFFC;
        exp_del = pre_target & 32'hFFFF_FFFC;
      end
      checks++;
      if (req_v && mem_pending) begin
        errors++; $display("FAIL rnd_outstanding c%0d: got second request while one pending expected none", i);
      end
    end
    redirect_v = 1'b0;
    ctrl       = '0;
    checks++;
    if (n_del < 150) begin errors++; $display("FAIL rnd_progress: got %0d deliveries expected at least 150", n_del); end
  endtask

  initial begin
    mem_pending = 1'b0;
    mem_addr    = 32'h0;
    mem_delay   = 0;
    test_reset();
    test_basic();
    test_ready_stall();
    test_stall_hold();
    test_redirect_wait();
    test_flush_redirect();
    test_wrap();
    test_reset();
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage and drives its fetch/decode pipeline register.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request, valid response interface, one request outstanding at a time.
- Presents fetched instructions to decode with their PC and PC+4.
- Obeys the stall/flush control for the fetch/decode register and accepts PC redirects from execute (branches, jumps).

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value after reset.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- fetchDecodeControl  input  control struct  .stall holds the output register; .flush invalidates it
- redirectValid  input  1  execute requests a PC change this cycle
- redirectTarget  input  32  new PC; bits [1:0] are forced to 0 on capture
- instructionRequestValid  output  1  fetch request pending
- instructionRequestReady  input  1  memory accepts request
- instructionRequestAddress  output  32  word address (the current PC)
- instructionResponseValid  input  1  response data valid; one per accepted request, at least 1 cycle after acceptance
- instructionResponseData  input  32  fetched instruction
- fetchDecodePayload  output  fetchDecodePayload_  fields: valid, instruction, programCounter, programCounterPlus4

Behaviour:
- Reset:
  - pc = RESET_VECTOR, state = REQUEST, discard = 0, hold buffer empty.
  - fetchDecodePayload = '0, so valid = 0.
  - instructionRequestValid = 0 in the reset cycle.
- States: REQUEST, WAIT, HOLD.
- REQUEST:
  - instructionRequestValid = 1; instructionRequestAddress = pc.
  - Address stays stable until instructionRequestReady is seen.
  - On valid & ready, go to WAIT.
- WAIT:
  - instructionRequestValid = 0.
  - Response arriving with discard = 1: drop it, clear discard, go to REQUEST.
  - Response arriving with discard = 0 and stall = 0: load the output register {valid=1, instruction, pc, pc+4}, set pc <= pc+4, go to REQUEST.
  - Response arriving with discard = 0 and stall = 1: capture {instruction, pc} in the hold buffer, set pc <= pc+4, go to HOLD.
- HOLD:
  - No request is issued.
  - When stall = 0, move the hold buffer into the output register with valid = 1, go to REQUEST.
- Bubbles: if stall = 0 and no instruction is delivered this cycle, the output register loads valid = 0.
- Output register priority: reset > flush > stall.
  - flush: only valid <= 0; other fields hold.
  - stall: all fields hold.
- Redirect (redirectValid = 1) has priority over all other PC and state updates:
  - pc <= {redirectTarget[31:2], 2'b00}.
  - Hold buffer is emptied.
  - State goes to REQUEST, except WAIT with no response this cycle, which stays in WAIT with discard = 1.
  - If the REQUEST handshake completes in the same cycle, go to WAIT with discard = 1.
  - If a response arrives in the same cycle, drop it.
  - The output register is not written with any fetched data this cycle. Execute asserts flush alongside the redirect; fetch does not invalidate on its own.
- Latency:
  - Zero-wait memory (ready = 1, response 1 cycle after acceptance): 1 instruction per 2 cycles.
  - Output appears the cycle after the response.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset in any state returns to the reset values. A response arriving while in REQUEST or HOLD is ignored.

Test Plan:
- Reset, then memory always ready, 1-cycle response, returning 32'h00000013 at addresses 0, 4 and 8 → requests to 0, 4, 8; payload valid with programCounter 0/4/8 and programCounterPlus4 4/8/12; valid = 0 in alternate cycles.
- Hold instructionRequestReady = 0 for 3 cycles at pc = 0x10 → instructionRequestValid stays 1 and the address stays 0x10 for the whole time; exactly one request is accepted.
- Response arrives with stall = 1 for 2 cycles → HOLD entered, payload unchanged; after stall drops, the payload shows the buffered instruction; the next request goes to the buffered pc+4.
- redirectValid with target 0x103 while in WAIT → the pending response is dropped, the next request goes to 0x100, and the dropped instruction never appears in the payload.
- flush and stall asserted together with a valid payload → valid cleared next cycle and the other fields unchanged; a redirect in the same cycle as a response delivers nothing from the old address.
- Redirect to 32'hFFFF_FFFC → payload programCounterPlus4 = 0 and the next request goes to address 0.
